// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//
// Shares the register file's single write port between three writeback
// requesters: execute results (0), memory load results (1) and the
// debug/host loader (2). Requesters are granted round-robin with
// valid/ready handshakes. The debug loader can take exclusive ownership of
// the port by completing a beat with dbgLock_i high, and it keeps ownership
// until it drops dbgLock_i. The accepted beat is registered onto the write
// port, so the register file never sees a combinational path from a
// requester.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   exValid_i/exAddr_i/exData_i    requester 0 beat, exReady_o accept
//   memValid_i/memAddr_i/memData_i requester 1 beat, memReady_o accept
//   dbgValid_i/dbgAddr_i/dbgData_i requester 2 beat, dbgReady_o accept
//   dbgLock_i                      debug asks for exclusive ownership
//   writeEnable_o/Addr_o/Data_o    registered register-file write port
//   locked_o                       high while debug owns the port
//   writeCount_o                   committed non-zero-address writes (wraps)

module regfile_write_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  exValid_i,
    input  logic [ADDR_WIDTH-1:0] exAddr_i,
    input  logic [DATA_WIDTH-1:0] exData_i,
    output logic                  exReady_o,
    input  logic                  memValid_i,
    input  logic [ADDR_WIDTH-1:0] memAddr_i,
    input  logic [DATA_WIDTH-1:0] memData_i,
    output logic                  memReady_o,
    input  logic                  dbgValid_i,
    input  logic [ADDR_WIDTH-1:0] dbgAddr_i,
    input  logic [DATA_WIDTH-1:0] dbgData_i,
    input  logic                  dbgLock_i,
    output logic                  dbgReady_o,
    output logic                  writeEnable_o,
    output logic [ADDR_WIDTH-1:0] writeAddr_o,
    output logic [DATA_WIDTH-1:0] writeData_o,
    output logic                  locked_o,
    output logic [CNT_WIDTH-1:0]  writeCount_o
);

    typedef enum logic {
        ST_ARB,
        ST_LOCKED
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            rr_ptr_q, rr_ptr_d;
    logic                  write_enable_q, write_enable_d;
    logic [ADDR_WIDTH-1:0] write_addr_q, write_addr_d;
    logic [DATA_WIDTH-1:0] write_data_q, write_data_d;
    logic [CNT_WIDTH-1:0]  write_count_q, write_count_d;

    logic [2:0]            grant;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;

    // Grant selection. In ARB the scan starts at rr_ptr_q and wraps mod 3;
    // in LOCKED only the debug loader may be granted. Nothing is granted
    // under reset so no beat can be lost to the register clear.
    always_comb begin
        grant = 3'b000;
        if (!rst) begin
            if (state_q == ST_LOCKED) begin
                grant[2] = dbgValid_i;
            end else begin
                case (rr_ptr_q)
                    2'd0: begin
                        if (exValid_i)       grant[0] = 1'b1;
                        else if (memValid_i) grant[1] = 1'b1;
                        else if (dbgValid_i) grant[2] = 1'b1;
                    end
                    2'd1: begin
                        if (memValid_i)      grant[1] = 1'b1;
                        else if (dbgValid_i) grant[2] = 1'b1;
                        else if (exValid_i)  grant[0] = 1'b1;
                    end
                    default: begin
                        if (dbgValid_i)      grant[2] = 1'b1;
                        else if (exValid_i)  grant[0] = 1'b1;
                        else if (memValid_i) grant[1] = 1'b1;
                    end
                endcase
            end
        end
    end

    assign exReady_o  = grant[0];
    assign memReady_o = grant[1];
    assign dbgReady_o = grant[2];

    // Next-state, pointer and write-port logic. The grant is one-hot, so a
    // simple priority mux picks the accepted beat's address and data.
    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        write_enable_d = 1'b0;
        write_addr_d   = write_addr_q;
        write_data_d   = write_data_q;
        write_count_d  = write_count_q;
        sel_addr       = dbgAddr_i;
        sel_data       = dbgData_i;

        if (grant[0]) begin
            sel_addr = exAddr_i;
            sel_data = exData_i;
        end else if (grant[1]) begin
            sel_addr = memAddr_i;
            sel_data = memData_i;
        end

        if (|grant) begin
            write_addr_d = sel_addr;
            write_data_d = sel_data;
            // Address 0 is the hard-wired zero register: accept, never write.
            if (sel_addr != '0) begin
                write_enable_d = 1'b1;
                write_count_d  = write_count_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end
        end

        case (state_q)
            ST_ARB: begin
                if (grant[0]) rr_ptr_d = 2'd1;
                if (grant[1]) rr_ptr_d = 2'd2;
                if (grant[2]) begin
                    rr_ptr_d = 2'd0;
                    if (dbgLock_i) state_d = ST_LOCKED;
                end
            end
            default: begin
                // Pointer stays frozen; the unlock cycle still grants debug only.
                if (!dbgLock_i) state_d = ST_ARB;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_ARB;
            rr_ptr_q       <= 2'd0;
            write_enable_q <= 1'b0;
            write_addr_q   <= '0;
            write_data_q   <= '0;
            write_count_q  <= '0;
        end else begin
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            write_enable_q <= write_enable_d;
            write_addr_q   <= write_addr_d;
            write_data_q   <= write_data_d;
            write_count_q  <= write_count_d;
        end
    end

    assign writeEnable_o = write_enable_q;
    assign writeAddr_o   = write_addr_q;
    assign writeData_o   = write_data_q;
    assign writeCount_o  = write_count_q;
    assign locked_o      = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Testbench for regfile_write_arbiter. Directed vectors carry the
// hand-computed grant for each cycle; every granted non-zero beat pushes its
// expected write (address, data, counter value) into a queue, and an
// independent monitor pops and compares whenever the write port is enabled.
// The counter is built 4 bits wide so that wrap-around is reachable.

module tb_regfile_write_arbiter;

    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int CW   = 4;
    localparam int NONE = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          exValid_i, memValid_i, dbgValid_i, dbgLock_i;
    logic [AW-1:0] exAddr_i, memAddr_i, dbgAddr_i;
    logic [DW-1:0] exData_i, memData_i, dbgData_i;
    logic          exReady_o, memReady_o, dbgReady_o;
    logic          writeEnable_o, locked_o;
    logic [AW-1:0] writeAddr_o;
    logic [DW-1:0] writeData_o;
    logic [CW-1:0] writeCount_o;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [CW-1:0] count;
    } exp_t;

    exp_t          exp_q[$];
    logic [CW-1:0] exp_count = '0;
    int            vectors = 0;
    int            miscompares = 0;

    regfile_write_arbiter #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .CNT_WIDTH (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .exValid_i    (exValid_i),
        .exAddr_i     (exAddr_i),
        .exData_i     (exData_i),
        .exReady_o    (exReady_o),
        .memValid_i   (memValid_i),
        .memAddr_i    (memAddr_i),
        .memData_i    (memData_i),
        .memReady_o   (memReady_o),
        .dbgValid_i   (dbgValid_i),
        .dbgAddr_i    (dbgAddr_i),
        .dbgData_i    (dbgData_i),
        .dbgLock_i    (dbgLock_i),
        .dbgReady_o   (dbgReady_o),
        .writeEnable_o(writeEnable_o),
        .writeAddr_o  (writeAddr_o),
        .writeData_o  (writeData_o),
        .locked_o     (locked_o),
        .writeCount_o (writeCount_o)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [63:0] actual,
                                input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drives one cycle of inputs (called at a falling edge), checks the
    // combinational readys against the hand-computed grant g and the lock
    // flag, records the expected commit, then waits for the next falling edge.
    task automatic apply_stimulus(
        input logic r,
        input logic ev, input logic [AW-1:0] ea, input logic [DW-1:0] ed,
        input logic mv, input logic [AW-1:0] ma, input logic [DW-1:0] md,
        input logic dv, input logic [AW-1:0] da, input logic [DW-1:0] dd,
        input logic dl, input int g, input logic el, input string name);
        logic [2:0]    exp_ready;
        exp_t          e;
        rst        = r;
        exValid_i  = ev;  exAddr_i  = ea;  exData_i  = ed;
        memValid_i = mv;  memAddr_i = ma;  memData_i = md;
        dbgValid_i = dv;  dbgAddr_i = da;  dbgData_i = dd;
        dbgLock_i  = dl;
        #1;
        exp_ready = (g <= 2) ? (3'b001 << g) : 3'b000;
        check_output({name, " readys"}, {61'd0, dbgReady_o, memReady_o, exReady_o},
                     {61'd0, exp_ready});
        check_output({name, " locked"}, {63'd0, locked_o}, {63'd0, el});
        if (r) begin
            exp_count = '0;
        end else if (g <= 2) begin
            e.addr = (g == 0) ? ea : (g == 1) ? ma : da;
            e.data = (g == 0) ? ed : (g == 1) ? md : dd;
            if (e.addr != '0) begin
                exp_count = exp_count + 1'b1;
                e.count   = exp_count;
                exp_q.push_back(e);
            end
        end
        @(negedge clk);
    endtask

    // Monitor: every enabled write must match the oldest expected commit.
    always @(negedge clk) begin
        if (writeEnable_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_output("unexpected write", {59'd0, writeAddr_o}, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check_output("write addr",  {59'd0, writeAddr_o},  {59'd0, e.addr});
                check_output("write data",  {32'd0, writeData_o},  {32'd0, e.data});
                check_output("write count", {60'd0, writeCount_o}, {60'd0, e.count});
            end
        end
    end

    initial begin
        rst = 1'b1;
        exValid_i = 0; memValid_i = 0; dbgValid_i = 0; dbgLock_i = 0;
        exAddr_i = '0; memAddr_i = '0; dbgAddr_i = '0;
        exData_i = '0; memData_i = '0; dbgData_i = '0;
        @(negedge clk);

        // Reset held with everything valid.
        for (int i = 0; i < 2; i++)
            apply_stimulus(1, 1, 5'd1, 32'hA, 1, 5'd2, 32'hB, 1, 5'd3, 32'hC, 0, NONE, 0, "reset");
        check_output("reset we",    {63'd0, writeEnable_o}, 64'd0);
        check_output("reset count", {60'd0, writeCount_o},  64'd0);
        check_output("reset addr",  {59'd0, writeAddr_o},   64'd0);
        check_output("reset data",  {32'd0, writeData_o},   64'd0);

        // Round-robin with all three valid: ex, mem, dbg, ex, mem, dbg.
        for (int i = 0; i < 6; i++)
            apply_stimulus(0, 1, 5'd1, 32'hA, 1, 5'd2, 32'hB, 1, 5'd3, 32'hC, 0, i % 3, 0, "rr");
        check_output("rr count", {60'd0, writeCount_o}, 64'd6);

        // Zero register: accepted but not written.
        apply_stimulus(0, 0, 5'd0, 32'h0, 1, 5'd0, 32'hFFFF_FFFF, 0, 5'd0, 32'h0, 0, 1, 0, "zero");
        check_output("zero we",    {63'd0, writeEnable_o}, 64'd0);
        check_output("zero addr",  {59'd0, writeAddr_o},   64'd0);
        check_output("zero data",  {32'd0, writeData_o},   64'h0000_0000_FFFF_FFFF);
        check_output("zero count", {60'd0, writeCount_o},  64'd6);
        apply_stimulus(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, NONE, 0, "idle");

        // Lock: debug wins (pointer at 2), then owns the port for four beats.
        apply_stimulus(0, 1, 5'd4, 32'h44, 1, 5'd10, 32'h55, 1, 5'd5, 32'h105, 1, 2, 0, "lock grant");
        for (int i = 0; i < 4; i++)
            apply_stimulus(0, 1, 5'd4, 32'h44, 1, 5'd10, 32'h55,
                           1, 5'(6 + i), 32'(32'h106 + i), 1, 2, 1, "locked beat");
        apply_stimulus(0, 1, 5'd4, 32'h44, 1, 5'd10, 32'h55, 0, 5'd0, 32'h0, 0, NONE, 1, "unlock");
        apply_stimulus(0, 1, 5'd4, 32'h44, 1, 5'd10, 32'h55, 0, 5'd0, 32'h0, 0, 0, 0, "resume ex");
        apply_stimulus(0, 0, 5'd0, 32'h0, 1, 5'd10, 32'h55, 0, 5'd0, 32'h0, 0, 1, 0, "resume mem");

        // Lock request without a debug transfer must not lock.
        apply_stimulus(0, 1, 5'd11, 32'h66, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 0, 0, "lock no grant");
        apply_stimulus(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, NONE, 0, "no lock held");

        // Counter wrap: commits 15, 16 and 17 leave a 4-bit counter at 1.
        for (int i = 0; i < 3; i++)
            apply_stimulus(0, 1, 5'(12 + i), 32'(32'h70 + i), 0, 5'd0, 32'h0,
                           0, 5'd0, 32'h0, 0, 0, 0, "wrap");
        check_output("wrap count", {60'd0, writeCount_o}, 64'd1);

        // Reset while ex is valid: no accept, no write, pointer back to ex.
        apply_stimulus(1, 1, 5'd13, 32'h77, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, NONE, 0, "mid reset");
        check_output("mid reset we",    {63'd0, writeEnable_o}, 64'd0);
        check_output("mid reset count", {60'd0, writeCount_o},  64'd0);
        apply_stimulus(0, 1, 5'd13, 32'h77, 1, 5'd14, 32'h88, 1, 5'd15, 32'h99, 0, 0, 0, "after reset");
        for (int i = 0; i < 3; i++)
            apply_stimulus(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, NONE, 0, "drain");

        check_output("final count",  {60'd0, writeCount_o}, 64'd1);
        check_output("queue drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the register file's single write port (write enable, 5-bit address, 32-bit data) between three writeback requesters: execute-stage results, memory-stage load results, and the debug/host loader. Arbitration is round-robin with valid/ready handshakes. The debug port can lock the write port for multi-word initialisation sequences. The block sits directly in front of the register file write port, and its registered outputs drive that port.

## Interface
- DATA_WIDTH, 32, write data width
- ADDR_WIDTH, 5, register address width; address 0 is the hard-wired zero register
- CNT_WIDTH, 16, width of the committed-write counter
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- exValid_i / exAddr_i / exData_i  in  1 / ADDR_WIDTH / DATA_WIDTH  requester 0 (execute writeback)
- exReady_o  out  1  requester 0 accepted this cycle
- memValid_i / memAddr_i / memData_i  in  1 / ADDR_WIDTH / DATA_WIDTH  requester 1 (load writeback)
- memReady_o  out  1  requester 1 accepted this cycle
- dbgValid_i / dbgAddr_i / dbgData_i  in  1 / ADDR_WIDTH / DATA_WIDTH  requester 2 (debug loader)
- dbgLock_i  in  1  debug requests exclusive ownership of the write port
- dbgReady_o  out  1  requester 2 accepted this cycle
- writeEnable_o / writeAddr_o / writeData_o  out  1 / ADDR_WIDTH / DATA_WIDTH  registered write port to the register file
- locked_o  out  1  high while in LOCKED state
- writeCount_o  out  CNT_WIDTH  number of committed non-zero-address writes

## Operation
- A transfer on requester k occurs when valid_k and ready_k are both high in the same cycle.
  - The requester must hold valid, addr and data stable until its ready is seen.
- readyN outputs are combinational from the valid inputs, the round-robin pointer and the state.
  - At most one ready is high per cycle.
  - All readys are 0 while rst=1.
- State machine, two states:
  - ARB (reset state): grant the first valid requester scanning from rrPtr upward, mod 3. On a transfer, rrPtr <= granted+1 mod 3.
  - ARB -> LOCKED: when requester 2 completes a transfer while dbgLock_i=1.
  - LOCKED: only requester 2 can be granted; exReady_o=memReady_o=0; rrPtr is frozen.
  - LOCKED -> ARB: on the first cycle dbgLock_i=0, evaluated at the clock edge. The grant in that cycle is still debug-only. ARB arbitration resumes the next cycle.
  - dbgLock_i high without a granted debug transfer does not lock.
- Commit: the accepted beat is registered into writeAddr_o/writeData_o, and writeEnable_o=1 for exactly one cycle.
  - A beat with address 0 is accepted (ready=1) but committed with writeEnable_o=0. It does not count.
  - Cycles with no transfer give writeEnable_o=0. Addr and data hold their last values.
- writeCount_o increments by 1 per committed non-zero write and wraps modulo 2^CNT_WIDTH.
- Reset values: writeEnable_o=0, writeAddr_o=0, writeData_o=0, writeCount_o=0, locked_o=0, rrPtr=0, state=ARB.
- Reset mid-operation: a beat accepted in the same cycle rst=1 is discarded. Since ready is 0 under reset, no transfer can occur.

## Timing
- Acceptance to write: a transfer at edge N gives writeEnable_o=1 during cycle N..N+1. The register file captures the data at edge N+1.
  - The register file's same-cycle write bypass covers reads in cycle N..N+1.
- Throughput: one write per cycle sustained, no bubbles between back-to-back grants.
- Worst-case wait in ARB with all three valid: 2 cycles.
- No combinational path from any valid input to writeEnable_o, writeAddr_o or writeData_o.

## Test plan
- Reset: hold rst 2 cycles with all valids high -> all readys 0, writeEnable_o=0, writeCount_o=0; first grant after release goes to ex (rrPtr=0).
- Round-robin: all three valid continuously with addrs 1/2/3, data 0xA/0xB/0xC -> grants ex, mem, dbg, ex...; writeEnable_o stays high every cycle from one cycle after the first grant; writes are (1,0xA), (2,0xB), (3,0xC) repeating; writeCount_o=6 after 6 commits.
- Zero register: mem writes addr 0, data 0xFFFFFFFF -> memReady_o=1, writeEnable_o stays 0, writeCount_o unchanged.
- Lock: dbg writes addr 5 with dbgLock_i=1 while ex and mem are valid -> locked_o=1 next cycle. Four further dbg beats (addrs 6..9) are granted back to back; ex/mem readys stay 0 throughout. Drop dbgLock_i -> locked_o=0 next cycle, then ex is granted.
- Counter wrap: with CNT_WIDTH=4, 17 non-zero commits -> writeCount_o=1.
- Mid-operation reset: assert rst in the cycle ex is valid -> no ready, no write the next cycle; after release, ex is granted with rrPtr=0.
